usb_tx: RTL and testbench

USB full-speed packet transmitter for the endpoint side of the device; it is the transmit counterpart to the USB receiver feeding the AHB-lite slave register block.
- Accepts a packet request (tx_packet) from the slave register block.
- For DATA0 packets, pulls payload bytes from the shared data buffer.
- Serialises SYNC, PID, payload, CRC16 and EOP onto D+/D- with bit stuffing and NRZI.
- Reports tx_transfer_active and tx_error back to the register block.

---
 rtl/usb_pkg.sv | 38 +++
 rtl/usb_crc16_tx.sv | 40 ++++
 rtl/usb_tx.sv | 253 +++++++++++++++++++++++++
 tb/tb_usb_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared USB transmit types and constants
//   tx_code_e  : request codes from the register block (NONE/DATA0/ACK/NAK)
//   tx_state_e : transmitter FSM states
//   PID_*, SYNC_BYTE, CRC16_POLY, CRC16_INIT, pid_for()
package usb_pkg;

    typedef enum logic [1:0] {
        TX_NONE  = 2'd0,
        TX_DATA0 = 2'd1,
        TX_ACK   = 2'd2,
        TX_NAK   = 2'd3
    } tx_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP
    } tx_state_e;

    localparam logic [7:0]  PID_DATA0  = 8'hC3;
    localparam logic [7:0]  PID_ACK    = 8'hD2;
    localparam logic [7:0]  PID_NAK    = 8'h5A;
    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [7:0] pid_for(input tx_code_e code);
        case (code)
            TX_ACK:  return PID_ACK;
            TX_NAK:  return PID_NAK;
            default: return PID_DATA0;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc16_tx.sv
// rtl/usb_crc16_tx.sv - serial CRC16 LFSR for the transmit payload
//   clk, n_rst : clock, asynchronous active-low reset
//   clr        : reload CRC16_INIT (takes priority over shift_en)
//   shift_en   : advance the LFSR by one payload bit
//   data_in    : payload bit (unstuffed, transmission order)
//   crc_out    : current CRC register
module usb_crc16_tx
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic        data_in,
    output logic [15:0] crc_out
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC16_INIT;
        end else if (shift_en) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ data_in) ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - USB full-speed packet transmitter (SYNC/PID/DATA/CRC16/EOP)
//   clk, n_rst         : clock, asynchronous active-low reset
//   tx_packet          : request code (tx_code_e), level-sampled
//   tx_packet_data     : payload byte at buffer head
//   buffer_occupancy   : bytes available in the data buffer
//   get_tx_packet_data : one-cycle pop strobe to the buffer
//   tx_transfer_active : high from request accept until end of EOP
//   tx_error           : one-cycle pulse when a conflicting request is rejected
//   dplus_out/dminus_out : NRZI-encoded, bit-stuffed line
module usb_tx
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] tx_packet,
    input  logic [7:0] tx_packet_data,
    input  logic [6:0] buffer_occupancy,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dplus_out,
    output logic       dminus_out
);

    localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [6:0]      MAX_B   = 7'(MAX_BYTES);

    tx_state_e        state_q, state_d;
    tx_code_e         code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [2:0]       ones_q, ones_d;
    logic [6:0]       bytes_q, bytes_d;
    logic             dp_q, dp_d;
    logic             dm_q, dm_d;
    logic             active_q, active_d;
    logic             err_q, err_d;

    logic        at_wrap;
    logic        emit;
    logic        emit_bit;
    logic        next_byte;
    logic        crc_clr;
    logic        crc_shift;
    logic [2:0]  nxt3;
    logic [3:0]  nxt4;
    logic [2:0]  ones_base;
    logic [7:0]  pid;
    logic [15:0] crc_out;
    tx_code_e    req;

    usb_crc16_tx u_crc (
        .clk      (clk),
        .n_rst    (n_rst),
        .clr      (crc_clr),
        .shift_en (crc_shift),
        .data_in  (emit_bit),
        .crc_out  (crc_out)
    );

    assign at_wrap   = (cnt_q == CNT_MAX);
    assign req       = tx_code_e'(tx_packet);
    assign pid       = pid_for(code_q);
    assign nxt3      = idx_q[2:0] + 3'd1;
    assign nxt4      = idx_q + 4'd1;
    // The stuffing run restarts with every packet, whatever the previous one left.
    assign ones_base = (state_q == ST_IDLE) ? 3'd0 : ones_q;

    always_comb begin
        state_d            = state_q;
        code_d             = code_q;
        cnt_d              = cnt_q;
        idx_d              = idx_q;
        shreg_d            = shreg_q;
        ones_d             = ones_q;
        bytes_d            = bytes_q;
        dp_d               = dp_q;
        dm_d               = dm_q;
        active_d           = active_q;
        err_d              = 1'b0;
        get_tx_packet_data = 1'b0;
        crc_clr            = 1'b0;
        crc_shift          = 1'b0;
        emit               = 1'b0;
        emit_bit           = 1'b0;
        next_byte          = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = at_wrap ? '0 : cnt_q + 1'b1;
            // Holding the accepted code is fine; anything else is rejected.
            // By the final J bit the requester must already have let go.
            err_d = (req != TX_NONE) &&
                    ((req != code_q) || (state_q == ST_EOP && idx_q == 4'd2));
        end

        case (state_q)
            ST_IDLE: begin
                if (req != TX_NONE) begin
                    code_d   = req;
                    state_d  = ST_SYNC;
                    idx_d    = 4'd0;
                    cnt_d    = '0;
                    bytes_d  = 7'd0;
                    active_d = 1'b1;
                    crc_clr  = 1'b1;
                    emit     = 1'b1;
                    emit_bit = SYNC_BYTE[0];
                end
            end
            ST_EOP: begin
                if (at_wrap) begin
                    if (idx_q == 4'd2) begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                    end else begin
                        idx_d = nxt4;
                        if (nxt4 == 4'd2) begin
                            dp_d = 1'b1;
                            dm_d = 1'b0;
                        end
                    end
                end
            end
            default: begin
                if (at_wrap) begin
                    if (ones_q == 3'd6) begin
                        // Stuff bit: position in the packet does not advance.
                        emit     = 1'b1;
                        emit_bit = 1'b0;
                    end else begin
                        case (state_q)
                            ST_SYNC: begin
                                emit = 1'b1;
                                if (idx_q == 4'd7) begin
                                    state_d  = ST_PID;
                                    idx_d    = 4'd0;
                                    emit_bit = pid[0];
                                end else begin
                                    idx_d    = nxt4;
                                    emit_bit = SYNC_BYTE[nxt3];
                                end
                            end
                            ST_PID: begin
                                if (idx_q != 4'd7) begin
                                    idx_d    = nxt4;
                                    emit     = 1'b1;
                                    emit_bit = pid[nxt3];
                                end else if (code_q == TX_DATA0) begin
                                    next_byte = 1'b1;
                                end else begin
                                    state_d = ST_EOP;
                                    idx_d   = 4'd0;
                                    dp_d    = 1'b0;
                                    dm_d    = 1'b0;
                                end
                            end
                            ST_DATA: begin
                                if (idx_q != 4'd7) begin
                                    idx_d     = nxt4;
                                    emit      = 1'b1;
                                    emit_bit  = shreg_q[nxt3];
                                    crc_shift = 1'b1;
                                end else begin
                                    next_byte = 1'b1;
                                end
                            end
                            ST_CRC: begin
                                if (idx_q != 4'd15) begin
                                    idx_d    = nxt4;
                                    emit     = 1'b1;
                                    // Bit 15 first: position n carries ~crc[15-n].
                                    emit_bit = ~crc_out[~nxt4];
                                end else begin
                                    state_d = ST_EOP;
                                    idx_d   = 4'd0;
                                    dp_d    = 1'b0;
                                    dm_d    = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        // Byte boundary: pop and send bit 0 of the new byte in the same cycle,
        // or fall through to the CRC with its first bit.
        if (next_byte) begin
            idx_d = 4'd0;
            emit  = 1'b1;
            if (buffer_occupancy != 7'd0 && bytes_q < MAX_B) begin
                get_tx_packet_data = 1'b1;
                shreg_d            = tx_packet_data;
                bytes_d            = bytes_q + 7'd1;
                state_d            = ST_DATA;
                emit_bit           = tx_packet_data[0];
                crc_shift          = 1'b1;
            end else begin
                state_d  = ST_CRC;
                emit_bit = ~crc_out[15];
            end
        end

        // NRZI: a logical 0 toggles J<->K, a logical 1 holds the line.
        if (emit) begin
            ones_d = emit_bit ? ones_base + 3'd1 : 3'd0;
            if (!emit_bit) begin
                dp_d = ~dp_q;
                dm_d = ~dm_q;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            code_q   <= TX_NONE;
            cnt_q    <= '0;
            idx_q    <= 4'd0;
            shreg_q  <= 8'h00;
            ones_q   <= 3'd0;
            bytes_q  <= 7'd0;
            dp_q     <= 1'b1;
            dm_q     <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            ones_q   <= ones_d;
            bytes_q  <= bytes_d;
            dp_q     <= dp_d;
            dm_q     <= dm_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

    assign dplus_out          = dp_q;
    assign dminus_out         = dm_q;
    assign tx_transfer_active = active_q;
    assign tx_error           = err_q;

endmodule

// File: tb/tb_usb_tx.sv
// tb/tb_usb_tx.sv - self-checking bench for usb_tx
module tb_usb_tx;

    logic       clk;
    logic       n_rst;
    logic [1:0] tx_packet;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       get_tx_packet_data;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       dplus_out;
    logic       dminus_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] buf_mem [0:127];
    int pop_cnt   = 0;
    int pop_start = 0;
    int occ_init  = 0;
    int err_cnt   = 0;

    logic [1:0] exp_q [$];

    usb_tx #(.CLKS_PER_BIT(8), .MAX_BYTES(64)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: head advances on each pop.
    assign buffer_occupancy = 7'(occ_init - (pop_cnt - pop_start));
    assign tx_packet_data   = buf_mem[7'(pop_cnt - pop_start)];

    always @(posedge clk) begin
        if (get_tx_packet_data) pop_cnt <= pop_cnt + 1;
        if (tx_error) err_cnt <= err_cnt + 1;
    end

    // Reference: logical bit list -> stuffing -> NRZI -> EOP, one entry per bit time.
    task automatic build_exp(input logic [1:0] code, input int nbytes);
        logic        bits [$];
        logic [7:0]  sb, pb, d;
        logic [15:0] crc;
        logic        line, fb;
        int          ones;
        sb = 8'h80;
        case (code)
            2'd1:    pb = 8'hC3;
            2'd2:    pb = 8'hD2;
            default: pb = 8'h5A;
        endcase
        for (int i = 0; i < 8; i++) bits.push_back(sb[i]);
        for (int i = 0; i < 8; i++) bits.push_back(pb[i]);
        if (code == 2'd1) begin
            crc = 16'hFFFF;
            for (int n = 0; n < nbytes; n++) begin
                d = buf_mem[n];
                for (int i = 0; i < 8; i++) begin
                    bits.push_back(d[i]);
                    fb  = crc[15] ^ d[i];
                    crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
                end
            end
            for (int i = 15; i >= 0; i--) bits.push_back(~crc[i]);
        end
        line = 1'b1;
        ones = 0;
        foreach (bits[k]) begin
            if (!bits[k]) line = ~line;
            exp_q.push_back({line, ~line});
            ones = bits[k] ? ones + 1 : 0;
            if (ones == 6) begin
                line = ~line;
                exp_q.push_back({line, ~line});
                ones = 0;
            end
        end
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
    endtask

    // Issue one request and check every bit time against the scoreboard.
    task automatic run_packet(input string name, input logic [1:0] code, input int occ,
                              input int hold, input int inject_c, input int exp_pops,
                              input int exp_errs);
        int          n_cyc;
        int          err_start;
        logic        act_ok;
        logic [15:0] samp;
        logic [1:0]  e;
        occ_init  = occ;
        pop_start = pop_cnt;
        err_start = err_cnt;
        exp_q.delete();
        build_exp(code, exp_pops);
        n_cyc  = 8 * exp_q.size();
        act_ok = 1'b1;
        samp   = 16'h0;
        @(negedge clk) tx_packet = code;
        @(posedge clk);
        for (int c = 0; c < n_cyc; c++) begin
            @(negedge clk);
            if (c == hold - 1) tx_packet = 2'd0;
            if (c == inject_c) tx_packet = 2'd3;
            else if (c == inject_c + 1) tx_packet = 2'd0;
            if (tx_transfer_active !== 1'b1) act_ok = 1'b0;
            samp = {samp[13:0], dplus_out, dminus_out};
            if (c % 8 == 7) begin
                e = exp_q.pop_front();
                n_checks++;
                if (samp !== {8{e}})
                    $display("FAIL %s bit %0d: line %h expected %h", name, c / 8, samp, {8{e}});
                else n_pass++;
            end
        end
        n_checks++;
        if (act_ok !== 1'b1) $display("FAIL %s active_during: dropped early, expected high throughout", name);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (tx_transfer_active !== 1'b0)
            $display("FAIL %s active_end: %b expected 0", name, tx_transfer_active);
        else n_pass++;
        n_checks++;
        if ((pop_cnt - pop_start) !== exp_pops)
            $display("FAIL %s pops: %0d expected %0d", name, pop_cnt - pop_start, exp_pops);
        else n_pass++;
        n_checks++;
        if ((err_cnt - err_start) !== exp_errs)
            $display("FAIL %s tx_error cycles: %0d expected %0d", name, err_cnt - err_start, exp_errs);
        else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic stable;
        n_rst     = 1'b0;
        tx_packet = 2'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({dplus_out, dminus_out} !== 2'b10) $display("FAIL reset line: %b expected 10", {dplus_out, dminus_out});
        else n_pass++;
        n_checks++;
        if (tx_transfer_active !== 1'b0) $display("FAIL reset active: %b expected 0", tx_transfer_active);
        else n_pass++;
        n_checks++;
        if (get_tx_packet_data !== 1'b0) $display("FAIL reset get: %b expected 0", get_tx_packet_data);
        else n_pass++;
        n_checks++;
        if (tx_error !== 1'b0) $display("FAIL reset tx_error: %b expected 0", tx_error);
        else n_pass++;
        n_rst  = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({dplus_out, dminus_out, tx_transfer_active, get_tx_packet_data, tx_error} !== 5'b10000)
                stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1) $display("FAIL idle_hold: outputs moved, expected J and inactive for 20 cycles");
        else n_pass++;
    endtask

    task automatic test_ack();
        run_packet("ack", 2'd2, 0, 1, -10, 0, 0);
    endtask

    task automatic test_data0_empty();
        // Request held for three cycles: equal code while active is not an error.
        run_packet("data0_empty", 2'd1, 0, 3, -10, 0, 0);
    endtask

    task automatic test_data0_ff();
        buf_mem[0] = 8'hFF;
        run_packet("data0_ff", 2'd1, 1, 1, -10, 1, 0);
    endtask

    task automatic test_data0_max();
        for (int i = 0; i < 128; i++) buf_mem[i] = 8'(i);
        run_packet("data0_max", 2'd1, 70, 1, -10, 64, 0);
        n_checks++;
        if (buffer_occupancy !== 7'd6) $display("FAIL data0_max occupancy: %0d expected 6", buffer_occupancy);
        else n_pass++;
    endtask

    task automatic test_error();
        logic quiet;
        run_packet("ack_err", 2'd2, 0, 1, 80, 0, 1);
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_transfer_active !== 1'b0 || {dplus_out, dminus_out} !== 2'b10) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) $display("FAIL ack_err follow_on: line active after ACK, expected idle J");
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic quiet;
        @(negedge clk) tx_packet = 2'd2;
        @(posedge clk);
        @(negedge clk) tx_packet = 2'd0;
        repeat (100) @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        n_checks++;
        if ({dplus_out, dminus_out} !== 2'b10) $display("FAIL reset_mid line: %b expected 10", {dplus_out, dminus_out});
        else n_pass++;
        n_checks++;
        if (tx_transfer_active !== 1'b0) $display("FAIL reset_mid active: %b expected 0", tx_transfer_active);
        else n_pass++;
        @(negedge clk) n_rst = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_transfer_active !== 1'b0 || {dplus_out, dminus_out} !== 2'b10) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) $display("FAIL reset_mid after: line moved, expected idle J with no EOP");
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) buf_mem[i] = 8'h00;
        test_reset();
        test_ack();
        test_data0_empty();
        test_data0_ff();
        test_data0_max();
        test_error();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
